// File: rtl/hyperbus_ctrl.sv
// hyperbus_ctrl
//   HyperBus transaction controller on the hbus clock domain. Turns native
//   word requests (rrq/wrq + address + 16-bit data) into HyperBus
//   transactions: CS#, 48-bit command-address, initial latency, burst data.
//   A DDR I/O shim downstream packs/unpacks two DQ bytes per clk and drives
//   CK while ck_en is high.
//
// Ports
//   clk, rst            controller clock, asynchronous active-high reset
//   adr_i               word address, sampled when a transaction starts
//   dat_i / ready       write word; ready pulses the cycle after a word is
//                       taken (dq_o shows that word in the same cycle)
//   dat_o / valid       read word; valid pulses one cycle after dq_valid
//   busy                transaction in progress (CS# low or CS# hold time)
//   err                 one-cycle pulse on read timeout abort
//   cs_n, ck_en         chip select (active low), CK enable for the shim
//   dq_o, dq_oe         {rising, falling} DQ bytes and output enable
//   rwds_o, rwds_oe     write byte mask {rising, falling}, 1 = masked
//   rwds_i              RWDS level in CA, 1 = double initial latency
//   dq_i, dq_valid      captured read word from the shim and its strobe
module hyperbus_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 6,
    parameter int CSHI       = 2,
    parameter int RD_TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  rrq,
    input  logic                  wrq,
    output logic                  ready,
    output logic                  valid,
    output logic                  busy,
    output logic                  err,
    output logic                  cs_n,
    output logic                  ck_en,
    output logic [DATA_WIDTH-1:0] dq_o,
    output logic                  dq_oe,
    output logic [1:0]            rwds_o,
    output logic                  rwds_oe,
    input  logic                  rwds_i,
    input  logic [DATA_WIDTH-1:0] dq_i,
    input  logic                  dq_valid
);

    localparam int LAT_W = $clog2(2 * LATENCY + 1);
    localparam int TO_W  = $clog2(RD_TIMEOUT + 1);
    localparam int END_W = $clog2(CSHI + 1);

    localparam logic [LAT_W-1:0] LAT_SHORT = LAT_W'(LATENCY - 1);
    localparam logic [LAT_W-1:0] LAT_LONG  = LAT_W'(2 * LATENCY - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(RD_TIMEOUT - 1);
    localparam logic [END_W-1:0] END_INIT  = END_W'(CSHI - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CA,
        S_LAT,
        S_WR,
        S_RD,
        S_END
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           adr_q, adr_d;
    logic                  dir_q, dir_d;        // 1 = read
    logic                  lat2_q, lat2_d;      // double latency selected
    logic [1:0]            ca_cnt_q, ca_cnt_d;  // index of CA word on the bus
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [END_W-1:0]      end_cnt_q, end_cnt_d;
    logic                  wr_term_q, wr_term_d; // masked closing word on bus

    logic                  cs_n_q, cs_n_d;
    logic                  ck_en_q, ck_en_d;
    logic [DATA_WIDTH-1:0] dq_o_q, dq_o_d;
    logic                  dq_oe_q, dq_oe_d;
    logic [1:0]            rwds_o_q, rwds_o_d;
    logic                  rwds_oe_q, rwds_oe_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;

    logic [31:0]           adr_in32;
    logic                  go_end;

    assign adr_in32 = 32'(adr_i);

    // Command-address word idx (0 = CA[47:32], MSB first).
    function automatic logic [15:0] ca_word(input logic       dir,
                                            input logic [31:0] a,
                                            input logic [1:0]  idx);
        case (idx)
            2'd0:    return {dir, 1'b0, 1'b1, a[31:19]};
            2'd1:    return a[18:3];
            default: return {13'b0, a[2:0]};
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dir_d     = dir_q;
        lat2_d    = lat2_q;
        ca_cnt_d  = ca_cnt_q;
        lat_cnt_d = lat_cnt_q;
        to_cnt_d  = to_cnt_q;
        end_cnt_d = end_cnt_q;
        wr_term_d = wr_term_q;
        cs_n_d    = cs_n_q;
        ck_en_d   = ck_en_q;
        dq_o_d    = dq_o_q;
        dq_oe_d   = dq_oe_q;
        rwds_o_d  = rwds_o_q;
        rwds_oe_d = rwds_oe_q;
        busy_d    = busy_q;
        dat_o_d   = dat_o_q;
        ready_d   = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        go_end    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rrq || wrq) begin
                    state_d  = S_CA;
                    adr_d    = adr_in32;
                    dir_d    = rrq;
                    cs_n_d   = 1'b0;
                    busy_d   = 1'b1;
                    ck_en_d  = 1'b1;
                    dq_oe_d  = 1'b1;
                    dq_o_d   = ca_word(rrq, adr_in32, 2'd0);
                    ca_cnt_d = 2'd0;
                end
            end
            S_CA: begin
                case (ca_cnt_q)
                    2'd0: begin
                        lat2_d   = rwds_i;
                        dq_o_d   = ca_word(dir_q, adr_q, 2'd1);
                        ca_cnt_d = 2'd1;
                    end
                    2'd1: begin
                        dq_o_d   = ca_word(dir_q, adr_q, 2'd2);
                        ca_cnt_d = 2'd2;
                    end
                    default: begin
                        state_d   = S_LAT;
                        dq_oe_d   = 1'b0;
                        dq_o_d    = '0;
                        lat_cnt_d = lat2_q ? LAT_LONG : LAT_SHORT;
                    end
                endcase
            end
            S_LAT: begin
                if (lat_cnt_q == '0) begin
                    if (dir_q) begin
                        state_d  = S_RD;
                        to_cnt_d = '0;
                    end else begin
                        state_d   = S_WR;
                        dq_oe_d   = 1'b1;
                        rwds_oe_d = 1'b1;
                        rwds_o_d  = 2'b00;
                        dq_o_d    = '0;
                        wr_term_d = 1'b0;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_WR: begin
                // The masked closing word stays on the bus for one cycle
                // with the output enables still on, then CS# rises.
                if (wr_term_q) begin
                    go_end = 1'b1;
                end else if (wrq) begin
                    dq_o_d  = dat_i;
                    ready_d = 1'b1;
                end else begin
                    rwds_o_d  = 2'b11;
                    wr_term_d = 1'b1;
                end
            end
            S_RD: begin
                if (!rrq) begin
                    go_end = 1'b1;
                end else if (dq_valid) begin
                    dat_o_d  = dq_i;
                    valid_d  = 1'b1;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d  = 1'b1;
                    go_end = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_END: begin
                if (end_cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    end_cnt_d = end_cnt_q - END_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (go_end) begin
            state_d   = S_END;
            cs_n_d    = 1'b1;
            ck_en_d   = 1'b0;
            dq_oe_d   = 1'b0;
            rwds_oe_d = 1'b0;
            dq_o_d    = '0;
            rwds_o_d  = 2'b00;
            end_cnt_d = END_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            adr_q     <= '0;
            dir_q     <= 1'b0;
            lat2_q    <= 1'b0;
            ca_cnt_q  <= '0;
            lat_cnt_q <= '0;
            to_cnt_q  <= '0;
            end_cnt_q <= '0;
            wr_term_q <= 1'b0;
            cs_n_q    <= 1'b1;
            ck_en_q   <= 1'b0;
            dq_o_q    <= '0;
            dq_oe_q   <= 1'b0;
            rwds_o_q  <= 2'b00;
            rwds_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            dat_o_q   <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dir_q     <= dir_d;
            lat2_q    <= lat2_d;
            ca_cnt_q  <= ca_cnt_d;
            lat_cnt_q <= lat_cnt_d;
            to_cnt_q  <= to_cnt_d;
            end_cnt_q <= end_cnt_d;
            wr_term_q <= wr_term_d;
            cs_n_q    <= cs_n_d;
            ck_en_q   <= ck_en_d;
            dq_o_q    <= dq_o_d;
            dq_oe_q   <= dq_oe_d;
            rwds_o_q  <= rwds_o_d;
            rwds_oe_q <= rwds_oe_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            dat_o_q   <= dat_o_d;
        end
    end

    assign cs_n    = cs_n_q;
    assign ck_en   = ck_en_q;
    assign dq_o    = dq_o_q;
    assign dq_oe   = dq_oe_q;
    assign rwds_o  = rwds_o_q;
    assign rwds_oe = rwds_oe_q;
    assign ready   = ready_q;
    assign valid   = valid_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign dat_o   = dat_o_q;

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// tb_hyperbus_ctrl
//   Scoreboard bench for hyperbus_ctrl. The driver issues requests and acts
//   as the HyperBus device, pushing the expected CA words, write data,
//   read data, latency and abort timing into queues; an independent
//   monitor pops and compares whenever the DUT shows the matching event.
module tb_hyperbus_ctrl;

    localparam int LATENCY    = 6;
    localparam int CSHI       = 2;
    localparam int RD_TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr_i;
    logic [15:0] dat_i, dat_o, dq_o, dq_i;
    logic        rrq, wrq, ready, valid, busy, err;
    logic        cs_n, ck_en, dq_oe, rwds_oe, rwds_i, dq_valid;
    logic [1:0]  rwds_o;

    always #5 clk = ~clk;

    hyperbus_ctrl #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(16),
        .LATENCY   (LATENCY),
        .CSHI      (CSHI),
        .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .adr_i   (adr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .rrq     (rrq),
        .wrq     (wrq),
        .ready   (ready),
        .valid   (valid),
        .busy    (busy),
        .err     (err),
        .cs_n    (cs_n),
        .ck_en   (ck_en),
        .dq_o    (dq_o),
        .dq_oe   (dq_oe),
        .rwds_o  (rwds_o),
        .rwds_oe (rwds_oe),
        .rwds_i  (rwds_i),
        .dq_i    (dq_i),
        .dq_valid(dq_valid)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_ca[$];
    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    int          exp_lat[$];
    int          exp_err[$];
    logic [1:0]  exp_mask[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Command-address built from the bit-field rules as a 48-bit number.
    function automatic logic [47:0] ca_model(bit rd, logic [31:0] a);
        logic [47:0] v;
        v = 48'(a >> 3) << 16;
        v = v | 48'(a & 32'h7);
        v = v | (48'd1 << 45);
        if (rd) v = v | (48'd1 << 47);
        return v;
    endfunction

    function automatic void push_ca(bit rd, logic [31:0] a);
        logic [47:0] v;
        v = ca_model(rd, a);
        exp_ca.push_back(v[47:32]);
        exp_ca.push_back(v[31:16]);
        exp_ca.push_back(v[15:0]);
    endfunction

    // ---------------- monitor ----------------
    int         mk = 0;
    logic       prev_cs = 1'b1, prev_busy = 1'b0, prev_rwds_oe = 1'b0;
    logic [1:0] prev_rwds = 2'b00;
    int         hi_cnt = 0;
    bit         lat_seen = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            mk = 0; prev_cs = 1'b1; prev_busy = 1'b0; prev_rwds_oe = 1'b0;
            prev_rwds = 2'b00; hi_cnt = 0; lat_seen = 1'b1;
        end else begin
            if (!cs_n && prev_cs) begin mk = 0; lat_seen = 1'b0; end
            else mk++;
            if (!cs_n && mk < 3) begin
                check("ca_pending", 64'(exp_ca.size() > 0), 64'd1);
                if (exp_ca.size() > 0) check("ca_word", dq_o, exp_ca.pop_front());
                check("ca_oe", {ck_en, dq_oe}, 2'b11);
            end
            if (!cs_n && mk >= 3 && dq_oe && !lat_seen) begin
                lat_seen = 1'b1;
                check("lat_pending", 64'(exp_lat.size() > 0), 64'd1);
                if (exp_lat.size() > 0) check("wr_latency", mk, exp_lat.pop_front());
            end
            if (ready) begin
                check("ready_expected", 64'(exp_wr.size() > 0), 64'd1);
                if (exp_wr.size() > 0) check("wr_data", dq_o, exp_wr.pop_front());
            end
            if (valid) begin
                check("valid_expected", 64'(exp_rd.size() > 0), 64'd1);
                if (exp_rd.size() > 0) check("rd_data", dat_o, exp_rd.pop_front());
            end
            if (err) begin
                check("err_expected", 64'(exp_err.size() > 0), 64'd1);
                if (exp_err.size() > 0) check("err_cycle", mk, exp_err.pop_front());
            end
            if (cs_n && !prev_cs && prev_rwds_oe) begin
                check("mask_expected", 64'(exp_mask.size() > 0), 64'd1);
                if (exp_mask.size() > 0) check("wr_term_mask", prev_rwds, exp_mask.pop_front());
            end
            if (cs_n && busy) hi_cnt++;
            if (!busy && prev_busy) begin
                check("cs_high_cycles", hi_cnt, CSHI);
                hi_cnt = 0;
            end
            prev_cs = cs_n; prev_busy = busy;
            prev_rwds_oe = rwds_oe; prev_rwds = rwds_o;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
        check("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_cs_low();
        int n = 0;
        do begin @(posedge clk); #1; n++; end while (cs_n !== 1'b0 && n < 20);
        check("cs_fall", cs_n, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] a, input int n, input bit rw,
                            input int abort_after, input logic [15:0] w0);
        int L, got, guard;
        logic [15:0] w;
        L = rw ? 2 * LATENCY : LATENCY;
        got = 0; guard = 0;
        push_ca(1'b0, a);
        exp_lat.push_back(3 + L);
        if (abort_after == 0) exp_mask.push_back(2'b11);
        adr_i = a; rwds_i = rw; dat_i = w0; exp_wr.push_back(w0); wrq = 1'b1;
        wait_cs_low();
        adr_i = $urandom;              // address must already be latched
        @(posedge clk); #1;
        rwds_i = ~rw;                  // only the first CA cycle counts
        while (got < n && guard < 200) begin
            @(posedge clk); #1; guard++;
            if (ready) begin
                got++;
                if (abort_after != 0 && got == abort_after) begin
                    #1 rst = 1'b1; wrq = 1'b0;
                    #1;
                    check("rst_cs_n", cs_n, 1'b1);
                    check("rst_dq_oe", dq_oe, 1'b0);
                    check("rst_busy", busy, 1'b0);
                    check("rst_ck_en", {ck_en, rwds_oe}, 2'b00);
                    exp_wr.delete(); exp_mask.delete();
                    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
                    return;
                end
                if (got < n) begin
                    w = $urandom; dat_i = w; exp_wr.push_back(w);
                end else begin
                    wrq = 1'b0; dat_i = $urandom;
                end
            end
        end
        check("write_words", got, n);
        wrq = 1'b0;
        wait_idle();
    endtask

    task automatic do_read(input logic [31:0] a, input int n, input bit rw,
                           input bit both, input int first_extra, input logic [15:0] d0);
        int L, rd0, k, sent, next_strobe, guard;
        bit fin;
        logic [15:0] d;
        L = rw ? 2 * LATENCY : LATENCY;
        rd0 = 3 + L;
        k = 0; sent = 0; guard = 0; fin = 1'b0;
        next_strobe = rd0 + first_extra;
        push_ca(1'b1, a);
        adr_i = a; rwds_i = rw; rrq = 1'b1; wrq = both; dat_i = $urandom;
        wait_cs_low();
        adr_i = $urandom;
        while (!fin && guard < 300) begin
            dq_valid = 1'b0;
            if (k == 1) rwds_i = ~rw;
            if (k == rd0 - 1) begin
                dq_valid = 1'b1; dq_i = $urandom;   // still in latency: ignored
            end else if (!rrq) begin
                fin = 1'b1;
            end else if (sent == n) begin
                rrq = 1'b0; wrq = 1'b0;
                dq_valid = 1'b1; dq_i = $urandom;   // after release: discarded
            end else if (k == next_strobe) begin
                d = (sent == 0) ? d0 : 16'($urandom);
                dq_valid = 1'b1; dq_i = d;
                if (rrq && k >= rd0) exp_rd.push_back(d);
                sent++;
                next_strobe = k + $urandom_range(1, 4);
            end
            if (!fin) begin @(posedge clk); #1; k++; guard++; end
        end
        check("read_strobes", sent, n);
        dq_valid = 1'b0; rrq = 1'b0; wrq = 1'b0;
        wait_idle();
    endtask

    task automatic do_timeout(input logic [31:0] a, input bit rw);
        int L, k;
        L = rw ? 2 * LATENCY : LATENCY;
        k = 0;
        push_ca(1'b1, a);
        exp_err.push_back(3 + L + RD_TIMEOUT);
        adr_i = a; rwds_i = rw; rrq = 1'b1;
        wait_cs_low();
        while (!(cs_n === 1'b1 && k > 3) && k < 200) begin @(posedge clk); #1; k++; end
        check("timeout_end", 64'(k), 64'(3 + L + RD_TIMEOUT));
        rrq = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; adr_i = '0; dat_i = '0; rrq = 1'b0; wrq = 1'b0;
        rwds_i = 1'b0; dq_i = '0; dq_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {cs_n, ck_en, dq_oe, rwds_oe, ready, valid, busy, err}, 8'b1000_0000);
        check("reset_data", {dq_o, rwds_o, dat_o}, 34'd0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_write(32'h0000_1234, 1, 1'b0, 0, 16'hBEEF);
        do_read(32'h0000_0010, 1, 1'b1, 1'b0, 0, 16'h5A5A);
        do_write($urandom, 4, 1'b0, 0, $urandom);
        do_timeout($urandom, 1'b0);
        do_write($urandom, 4, 1'b0, 2, $urandom);
        do_write($urandom, 1, 1'b0, 0, $urandom);
        do_read($urandom, 3, 1'b0, 1'b1, 1, $urandom);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)), 0, $urandom);
            else
                do_read($urandom, $urandom_range(1, 4), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
        end

        repeat (4) @(posedge clk);
        #1;
        check("ca_drained", exp_ca.size(), 0);
        check("wr_drained", exp_wr.size(), 0);
        check("rd_drained", exp_rd.size(), 0);
        check("lat_drained", exp_lat.size(), 0);
        check("err_drained", exp_err.size(), 0);
        check("mask_drained", exp_mask.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_ctrl.md
Name: hyperbus_ctrl

Overview:
HyperBus transaction controller, directly downstream of the dual-clock FIFO bridge on the hbus clock domain. It accepts native word requests (rrq/wrq, address, 16-bit data) and sequences HyperBus transactions: CS#, 48-bit command-address, initial latency, and burst data. It drives a DDR I/O shim that packs two DQ bytes per clk. The shim is external to this block and also drives CK from ck_en.

Parameters:
ADDR_WIDTH, 32, native word address width (adr_i).
DATA_WIDTH, 16, native data width; fixed at 16 (one DDR CK period).
LATENCY, 6, initial latency in clk cycles after CA (single).
CSHI, 2, minimum clk cycles CS# held high between transactions.
RD_TIMEOUT, 32, max clk cycles waiting for each read word before abort.

Ports:
clk  in  1  controller clock (hbus domain)
rst  in  1  asynchronous active-high reset
adr_i  in  ADDR_WIDTH  word address, sampled at transaction start
dat_i  in  16  write data word
dat_o  out  16  read data word
rrq  in  1  read request; held for the burst
wrq  in  1  write request; held for the burst
ready  out  1  1-cycle pulse: dat_i consumed
valid  out  1  1-cycle pulse: dat_o holds a read word
busy  out  1  transaction in progress
err  out  1  1-cycle pulse: read timeout abort
cs_n  out  1  HyperBus chip select, active low
ck_en  out  1  enable CK toggling in the shim
dq_o  out  16  {rising byte, falling byte} to DQ
dq_oe  out  1  DQ output enable
rwds_o  out  2  write byte mask {rising, falling}, 1 = masked
rwds_oe  out  1  RWDS output enable
rwds_i  in  1  RWDS level sampled during CA (latency indicator)
dq_i  in  16  captured read word from shim
dq_valid  in  1  shim strobe: dq_i valid this cycle

Behaviour:
- Reset, and its async assertion at any point: cs_n=1, ck_en=0, dq_oe=0, rwds_oe=0, dq_o=0, rwds_o=0, ready=valid=busy=err=0, dat_o=0, state IDLE. A transaction in flight is dropped; CS# rises immediately.
- States: IDLE -> CA -> LAT -> (WR | RD) -> END -> IDLE.
- IDLE: if rrq or wrq is high, latch adr_i, latch dir (rrq wins if both are high), go to CA. On the same edge: cs_n<=0, busy<=1.
- CA: 3 cycles; ck_en=1, dq_oe=1. CA[47]=dir (1 = read), CA[46]=0 (memory space), CA[45]=1 (linear burst), CA[44:16]=adr[31:3], CA[15:3]=0, CA[2:0]=adr[2:0]. Words driven MSB first: CA[47:32], CA[31:16], CA[15:0]. rwds_i sampled on the first CA cycle: 1 selects latency 2*LATENCY, else LATENCY.
- LAT: dq_oe=0, count down the selected latency. Exit to WR or RD when the counter reaches 0.
- WR: dq_oe=rwds_oe=1, rwds_o=2'b00, dq_o=dat_i. Each cycle with wrq=1: ready=1 for that cycle. The first cycle with wrq=0 drives rwds_o=2'b11 (masked) and goes to END. ready is never asserted while wrq=0.
- RD: dq_oe=0. On dq_valid with rrq=1: dat_o<=dq_i, valid=1 next cycle (1-cycle registered latency). On rrq=0: go to END; words arriving after that are discarded. The timeout counter resets on each dq_valid. If it reaches RD_TIMEOUT: err pulse, go to END.
- END: cs_n=1, ck_en=0, all OEs 0. Hold CSHI cycles, then busy<=0 and go to IDLE. Requests present in END are not accepted until IDLE.
- Address is not incremented internally; the device burst counter advances. A burst must not cross the device page; that is the requester's responsibility.
- Counters saturate, never wrap. The latency counter is sized for 2*LATENCY.

Test Plan:
- Single write, adr_i=0x00001234, dat_i=0xBEEF, rwds_i=0:
  - CA words 0x2000, 0x0246, 0x0004.
  - 6 latency cycles, then dq_o=0xBEEF with exactly one ready pulse.
  - cs_n high for 2 cycles; busy drops after.
- Read with rwds_i=1 during CA, adr_i=0x10:
  - First CA word 0xA000.
  - 12 latency cycles observed.
  - dq_valid with dq_i=0x5A5A -> valid pulse with dat_o=0x5A5A one cycle later.
- Burst write of 4 words (wrq held 4 ready pulses): dq_o sequence matches the input words; rwds_o=2'b11 on the terminating cycle.
- Read timeout: rrq held, no dq_valid -> err pulses after 32 cycles in RD; cs_n rises; no valid pulse.
- Async rst asserted mid-WR: cs_n=1, dq_oe=0, busy=0 with no clock edge. After release, the next wrq starts a fresh CA.
- rrq and wrq both high in IDLE: read issued (CA[47]=1), no ready pulses.
